// File: rtl/alu_mc_pkg.sv
`default_nettype none
// ============================================================================
// alu_mc_pkg : opcode and state encodings shared by the alu_mc block
// Rev 1.0
// ============================================================================
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SHL = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_SUB = 4'd4,
        OP_SHR = 4'd5,
        OP_CMP = 4'd6,
        OP_MUL = 4'd7,
        OP_XOR = 4'd8,
        OP_ROL = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic ILLEGAL_SCO = 1'b1;

endpackage
`default_nettype wire

// File: rtl/alu_mc_mul.sv
`default_nettype none
// ============================================================================
// alu_mc_mul : iterative shift-add multiplier, one multiplier bit per cycle
// Rev 1.0
// ============================================================================
module alu_mc_mul #(
    parameter int W  = 8,
    parameter int CW = $clog2(W) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam logic [CW-1:0] STEPS = CW'(W);

    logic [W-1:0]   mcand;
    logic [2*W-1:0] prod;
    logic [CW-1:0]  cnt;
    logic           busy;
    logic [W:0]     sum;

    // Upper half accumulates; the multiplier drains out of the lower half.
    assign sum = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? mcand : {W{1'b0}})};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            mcand <= a;
            prod  <= {{W{1'b0}}, b};
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            if (cnt == STEPS) begin
                busy <= 1'b0;
            end else begin
                prod <= {sum, prod[W-1:1]};
                cnt  <= cnt + 1'b1;
            end
        end
    end

    assign done    = busy && (cnt == STEPS);
    assign product = prod;

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// alu_mc : handshaked ALU with single-cycle ops and an optional iterative MUL
//          enabled by defining ALU_MC_MUL_EN.  Rev 1.0
// ============================================================================
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W) + 1
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         In_valid,
    output logic         In_ready,
    input  logic [3:0]   Aluop,
    input  logic [W-1:0] DatA,
    input  logic [W-1:0] DatB,
    output logic         Out_valid,
    input  logic         Out_ready,
    output logic [W-1:0] Rslt,
    output logic [W-1:0] Rslt_hi,
    output logic         Zero,
    output logic         Par,
    output logic         SCo
);

    localparam logic [W-1:0] W_V   = W'(W);
    localparam logic [W-1:0] ONE_W = W'(1);

    state_e         state;
    state_e         state_nxt;
    logic           load_alu;
    logic           load_mul;
    logic           mul_start;
    logic           mul_sel;
    logic           mul_done;
    logic [2*W-1:0] mul_prod;

    logic [W-1:0]   alu_lo;
    logic           alu_co;
    logic [W:0]     wide;
    logic [W-1:0]   shr_mask;
    logic [W-1:0]   rol_amt;

    logic [W-1:0]   res_lo;
    logic [W-1:0]   res_hi;
    logic           carry;

    always_comb begin
        alu_lo   = '0;
        alu_co   = 1'b0;
        wide     = '0;
        shr_mask = '0;
        rol_amt  = '0;
        case (Aluop)
            OP_ADD: begin
                wide   = {1'b0, DatA} + {1'b0, DatB};
                alu_lo = wide[W-1:0];
                alu_co = wide[W];
            end
            OP_SHL: begin
                if (DatB <= W_V) begin
                    wide = {1'b0, DatA} << DatB;
                end
                alu_lo = wide[W-1:0];
                alu_co = wide[W];
            end
            OP_AND: alu_lo = DatA & DatB;
            OP_OR:  alu_lo = DatA | DatB;
            OP_SUB: begin
                wide   = {1'b0, DatA} - {1'b0, DatB};
                alu_lo = wide[W-1:0];
                alu_co = wide[W];
            end
            OP_SHR: begin
                alu_lo = DatA >> DatB;
                // Carry-out is the last bit shifted out, A[B-1].
                if ((DatB != '0) && (DatB <= W_V)) begin
                    shr_mask = ONE_W << (DatB - ONE_W);
                    alu_co   = |(DatA & shr_mask);
                end
            end
            OP_CMP: alu_lo = {{(W-2){1'b0}}, (DatA > DatB), (DatA != DatB)};
            OP_XOR: alu_lo = DatA ^ DatB;
            OP_ROL: begin
                rol_amt = DatB % W_V;
                alu_lo  = (DatA << rol_amt) | (DatA >> (W_V - rol_amt));
            end
            default: alu_co = ILLEGAL_SCO;
        endcase
    end

`ifdef ALU_MC_MUL_EN
    assign mul_sel = (Aluop == OP_MUL);

    alu_mc_mul #(
        .W  (W),
        .CW (CW)
    ) u_mul (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .start   (mul_start),
        .a       (DatA),
        .b       (DatB),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    logic unused_cfg;

    assign mul_sel    = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_prod   = '0;
    assign unused_cfg = (CW > 0) ^ mul_start;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        mul_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (In_valid) begin
                    if (mul_sel) begin
                        state_nxt = ST_BUSY;
                        mul_start = 1'b1;
                    end else begin
                        state_nxt = ST_DONE;
                        load_alu  = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_nxt = ST_DONE;
                    load_mul  = 1'b1;
                end
            end
            ST_DONE: begin
                if (Out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            res_lo <= '0;
            res_hi <= '0;
            carry  <= 1'b0;
        end else if (load_alu) begin
            res_lo <= alu_lo;
            res_hi <= '0;
            carry  <= alu_co;
        end else if (load_mul) begin
            res_lo <= mul_prod[W-1:0];
            res_hi <= mul_prod[2*W-1:W];
            carry  <= |mul_prod[2*W-1:W];
        end
    end

    assign In_ready  = (state == ST_IDLE);
    assign Out_valid = (state == ST_DONE);
    assign Rslt      = res_lo;
    assign Rslt_hi   = res_hi;
    assign SCo       = carry;
    assign Zero      = ~|{res_hi, res_lo};
    assign Par       = ^res_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// tb_alu_mc : directed self-checking bench for alu_mc (W = 8)
// Rev 1.0
// ============================================================================
module tb_alu_mc;

    localparam int W = 8;

    logic         Clk       = 1'b0;
    logic         Rst_n     = 1'b0;
    logic         In_valid  = 1'b0;
    logic         Out_ready = 1'b1;
    logic [3:0]   Aluop     = 4'h0;
    logic [W-1:0] DatA      = '0;
    logic [W-1:0] DatB      = '0;
    logic         In_ready;
    logic         Out_valid;
    logic [W-1:0] Rslt;
    logic [W-1:0] Rslt_hi;
    logic         Zero;
    logic         Par;
    logic         SCo;

    int total = 0;
    int bad   = 0;

    alu_mc #(.W(W)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Aluop     (Aluop),
        .DatA      (DatA),
        .DatB      (DatB),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Rslt      (Rslt),
        .Rslt_hi   (Rslt_hi),
        .Zero      (Zero),
        .Par       (Par),
        .SCo       (SCo)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_r, input logic exp_c);
        Aluop     = op;
        DatA      = a;
        DatB      = b;
        In_valid  = 1'b1;
        Out_ready = 1'b1;
        chk({tag, "/in_ready"}, 32'(In_ready), 32'd1);
        step();
        In_valid = 1'b0;
        DatA     = ~a;
        DatB     = ~b;
        Aluop    = 4'h0;
        chk({tag, "/out_valid"}, 32'(Out_valid), 32'd1);
        chk({tag, "/rslt"},      32'(Rslt),      32'(exp_r));
        chk({tag, "/rslt_hi"},   32'(Rslt_hi),   32'd0);
        chk({tag, "/sco"},       32'(SCo),       32'(exp_c));
        chk({tag, "/zero"},      32'(Zero),      32'(exp_r == '0));
        chk({tag, "/par"},       32'(Par),       32'(^exp_r));
        step();
        chk({tag, "/consumed"},  32'(Out_valid), 32'd0);
        chk({tag, "/reready"},   32'(In_ready),  32'd1);
    endtask

    initial begin
        // Reset state while Rst_n is held low
        #2;
        chk("rst/out_valid", 32'(Out_valid), 32'd0);
        chk("rst/in_ready",  32'(In_ready),  32'd1);
        chk("rst/rslt",      32'(Rslt),      32'd0);
        chk("rst/rslt_hi",   32'(Rslt_hi),   32'd0);
        chk("rst/sco",       32'(SCo),       32'd0);
        chk("rst/zero",      32'(Zero),      32'd1);
        chk("rst/par",       32'(Par),       32'd0);
        #20;
        Rst_n = 1'b1;
        step();
        chk("rel/in_ready", 32'(In_ready), 32'd1);

        run_op("add",      4'd0, 8'hF0, 8'h20, 8'h10, 1'b1);
        run_op("sub_eq",   4'd4, 8'h05, 8'h05, 8'h00, 1'b0);
        run_op("sub_brw",  4'd4, 8'h03, 8'h05, 8'hFE, 1'b1);
        run_op("shl_1",    4'd1, 8'h81, 8'h01, 8'h02, 1'b1);
        run_op("shl_w",    4'd1, 8'h81, 8'h08, 8'h00, 1'b1);
        run_op("shl_big",  4'd1, 8'h81, 8'h09, 8'h00, 1'b0);
        run_op("and",      4'd2, 8'hF0, 8'h3C, 8'h30, 1'b0);
        run_op("or",       4'd3, 8'hF0, 8'h3C, 8'hFC, 1'b0);
        run_op("xor",      4'd8, 8'hF0, 8'h3C, 8'hCC, 1'b0);
        run_op("cmp_gt",   4'd6, 8'h05, 8'h03, 8'h03, 1'b0);
        run_op("cmp_lt",   4'd6, 8'h03, 8'h05, 8'h01, 1'b0);
        run_op("cmp_eq",   4'd6, 8'h07, 8'h07, 8'h00, 1'b0);
        run_op("rol_9",    4'd9, 8'h81, 8'h09, 8'h03, 1'b0);
        run_op("rol_0",    4'd9, 8'h81, 8'h00, 8'h81, 1'b0);
        run_op("shr_w",    4'd5, 8'h81, 8'h08, 8'h00, 1'b1);
        run_op("shr_0",    4'd5, 8'h81, 8'h00, 8'h81, 1'b0);
        run_op("shr_big",  4'd5, 8'h81, 8'h09, 8'h00, 1'b0);
        run_op("ill_f",    4'hF, 8'h12, 8'h34, 8'h00, 1'b1);
        run_op("ill_a",    4'hA, 8'hFF, 8'h01, 8'h00, 1'b1);
`ifndef ALU_MC_MUL_EN
        run_op("ill_7",    4'd7, 8'hFF, 8'hFF, 8'h00, 1'b1);
`endif

        // Backpressure: result held, new requests ignored until consumed
        Aluop     = 4'd5;
        DatA      = 8'h81;
        DatB      = 8'h01;
        In_valid  = 1'b1;
        Out_ready = 1'b0;
        step();
        Aluop = 4'd0;
        DatA  = 8'h01;
        DatB  = 8'h01;
        for (int i = 0; i < 5; i++) begin
            chk("bp/out_valid", 32'(Out_valid), 32'd1);
            chk("bp/rslt",      32'(Rslt),      32'h40);
            chk("bp/sco",       32'(SCo),       32'd1);
            chk("bp/in_ready",  32'(In_ready),  32'd0);
            step();
        end
        In_valid  = 1'b0;
        Out_ready = 1'b1;
        step();
        chk("bp/released",  32'(Out_valid), 32'd0);
        chk("bp/in_ready2", 32'(In_ready),  32'd1);
        chk("bp/no_accept", 32'(Rslt),      32'h40);
        step();
        chk("bp/idle",      32'(Out_valid), 32'd0);

        // Reset with an unconsumed result pending
        Aluop     = 4'd0;
        DatA      = 8'h11;
        DatB      = 8'h22;
        In_valid  = 1'b1;
        Out_ready = 1'b0;
        step();
        In_valid = 1'b0;
        chk("rdone/out_valid", 32'(Out_valid), 32'd1);
        chk("rdone/rslt",      32'(Rslt),      32'h33);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("rdone/async_ov",  32'(Out_valid), 32'd0);
        chk("rdone/async_rdy", 32'(In_ready),  32'd1);
        chk("rdone/async_z",   32'(Zero),      32'd1);
        #3;
        Rst_n     = 1'b1;
        Out_ready = 1'b1;
        step();
        chk("rdone/after_ov",  32'(Out_valid), 32'd0);
        chk("rdone/after_rdy", 32'(In_ready),  32'd1);

`ifdef ALU_MC_MUL_EN
        // MUL: W+1 cycles of latency, other requests ignored while busy
        Aluop     = 4'd7;
        DatA      = 8'hFF;
        DatB      = 8'hFF;
        In_valid  = 1'b1;
        Out_ready = 1'b1;
        step();
        Aluop = 4'd0;
        DatA  = 8'h01;
        DatB  = 8'h02;
        for (int i = 0; i < 9; i++) begin
            chk("mul/busy_ov",  32'(Out_valid), 32'd0);
            chk("mul/busy_rdy", 32'(In_ready),  32'd0);
            step();
        end
        In_valid = 1'b0;
        chk("mul/out_valid", 32'(Out_valid),        32'd1);
        chk("mul/product",   32'({Rslt_hi, Rslt}),  32'hFE01);
        chk("mul/sco",       32'(SCo),              32'd1);
        chk("mul/zero",      32'(Zero),             32'd0);
        chk("mul/par",       32'(Par),              32'd1);
        step();
        chk("mul/consumed",  32'(Out_valid), 32'd0);
        run_op("add_after_mul", 4'd0, 8'h01, 8'h02, 8'h03, 1'b0);

        // Reset in the fourth BUSY cycle
        Aluop    = 4'd7;
        DatA     = 8'h0F;
        DatB     = 8'h0F;
        In_valid = 1'b1;
        step();
        In_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        #2;
        Rst_n = 1'b0;
        #1;
        chk("rmul/async_ov",  32'(Out_valid), 32'd0);
        chk("rmul/async_rdy", 32'(In_ready),  32'd1);
        #3;
        Rst_n = 1'b1;
        step();
        chk("rmul/in_ready", 32'(In_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            chk("rmul/no_stale", 32'(Out_valid), 32'd0);
            step();
        end
        chk("rmul/rslt",    32'({Rslt_hi, Rslt}), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter W, default 8: operand/result width; legal range 4..32.
REQ-002 SHALL have parameter CW, default $clog2(W)+1: multiply iteration counter width.
REQ-003 SHALL have port Clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port Rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port In_valid, input, 1: operation request present.
REQ-006 SHALL have port In_ready, output, 1: block accepts a request this cycle.
REQ-007 SHALL have port Aluop, input, 4: operation code, sampled on accept.
REQ-008 SHALL have ports DatA and DatB, input, W each: operands, sampled on accept.
REQ-009 SHALL have port Out_valid, output, 1: result registers hold a valid result.
REQ-010 SHALL have port Out_ready, input, 1: consumer takes the result.
REQ-011 SHALL have ports Rslt and Rslt_hi, output, W each: result; Rslt_hi nonzero only for MUL.
REQ-012 SHALL have ports Zero, Par and SCo, output, 1 each: registered flags of the result.

Function
REQ-013 SHALL accept a request when In_valid && In_ready; In_ready = (state == IDLE).
REQ-014 SHALL implement states IDLE, BUSY and DONE: IDLE->DONE on single-cycle-op accept; IDLE->BUSY on MUL accept; BUSY->DONE when the counter reaches W; DONE->IDLE when Out_ready.
REQ-015 SHALL assert Out_valid exactly in DONE, holding Rslt, Rslt_hi and the flags stable until Out_ready.
REQ-016 SHALL give single-cycle ops latency 1: Out_valid is high in the cycle after accept.
REQ-017 SHALL compute MUL by iterative shift-add, one multiplier bit per cycle, with Out_valid high W+1 cycles after accept.
REQ-018 SHALL decode Aluop as follows, all arithmetic unsigned:
- 0 ADD: {SCo,Rslt} = A+B.
- 1 SHL: {SCo,Rslt} = ({0,A}<<B) truncated to W+1 bits; 0 when B > W.
- 2 AND and 3 OR: SCo = 0.
- 4 SUB: {SCo,Rslt} = A-B in W+1 bits, so SCo = borrow (A<B).
- 5 SHR: Rslt = A>>B; SCo = A[B-1] for 1<=B<=W, else 0.
- 6 CMP: Rslt[0] = (A!=B), Rslt[1] = (A>B), all other bits 0, SCo = 0.
- 7 MUL: {Rslt_hi,Rslt} = A*B; SCo = |Rslt_hi.
- 8 XOR: SCo = 0.
- 9 ROL by B mod W: SCo = 0.
- 10..15: illegal; Rslt = 0, SCo = 1, latency 1.
REQ-019 SHALL compute Zero = ~|{Rslt_hi,Rslt} and Par = ^Rslt from the same values registered on the outputs.
REQ-020 SHALL hold Rslt_hi at 0 for every non-MUL op.
REQ-021 SHALL ignore In_valid, Aluop and operands while in BUSY or DONE; operands are latched, so input changes after accept have no effect.
REQ-022 SHALL allow a new accept in the cycle after DONE->IDLE; peak throughput is one op per 2 cycles.

Reset
REQ-023 SHALL, on Rst_n low, asynchronously force state = IDLE and clear counter, Out_valid, Rslt, Rslt_hi and SCo to 0; Zero therefore reads 1 and Par 0.
REQ-024 SHALL abandon any in-flight MUL or unconsumed result when Rst_n asserts mid-operation, emitting no result afterwards.
REQ-025 SHALL assert In_ready in the first clock after Rst_n deasserts.

Configuration
REQ-026 SHALL, with ALU_MC_MUL_EN defined, include the MUL datapath and BUSY state per REQ-017.
REQ-027 SHALL, without ALU_MC_MUL_EN, treat Aluop 7 as illegal (REQ-018), never enter BUSY, and synthesise no multiply accumulator or counter.

Structure
REQ-028 SHALL place the 4-bit opcode enum (ADD..ROL), the state enum and the ILLEGAL_SCO constant in shared package alu_mc_pkg.
REQ-029 SHALL implement the iterative multiplier as sub-module alu_mc_mul (start/done handshake, parameter W), instantiated only under ALU_MC_MUL_EN.

Verification
REQ-030 SHALL cover ADD at W=8, A=8'hF0, B=8'h20, Out_ready=1 -> next cycle Rslt=8'h10, SCo=1, Zero=0, Par=1.
REQ-031 SHALL cover SUB at W=8, A=5, B=5 -> Rslt=0, Zero=1, SCo=0; then A=3, B=5 -> Rslt=8'hFE, SCo=1.
REQ-032 SHALL cover MUL at W=8, A=8'hFF, B=8'hFF -> Out_valid exactly 9 cycles after accept; {Rslt_hi,Rslt}=16'hFE01, SCo=1; In_ready low throughout.
REQ-033 SHALL cover backpressure: SHR A=8'h81, B=1 with Out_ready=0 for 5 cycles -> Rslt=8'h40, SCo=1 held stable; new In_valid ignored until consumed.
REQ-034 SHALL cover reset mid-MUL: Rst_n low at cycle 4 of BUSY -> Out_valid=0, In_ready=1 after release, no stale result.
REQ-035 SHALL cover illegal op: Aluop=4'hF -> Rslt=0, Zero=1, SCo=1; with ALU_MC_MUL_EN undefined, Aluop=7 gives the same.
